// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared single-precision field widths, arbiter FSM states and a zero test
package fp_mul_pkg;
  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  function automatic logic is_zero(input logic [FP_W-1:0] fp);
    return fp[MAN_W +: EXP_W] == '0 && fp[MAN_W-1:0] == '0;
  endfunction
endpackage

// File: rtl/fp_mul_rr_arbiter.sv
// fp_mul_rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
// req_i: request vector; ptr_i: highest-priority index
// gnt_o: one-hot grant; idx_o: binary index of the grant (0 when nothing requests)
module fp_mul_rr_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);
  logic [ID_W-1:0] j;
  // Walk from the farthest candidate back to ptr_i so the nearest hit is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[j]) begin
        gnt_o = NUM_REQ'(1) << j;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one FP32 multiplier between NUM_REQ requesters with round-robin grant
// req_valid/req_a/req_b/req_ready: per-requester request channels (operands packed 32*i)
// mul_a/mul_b/mul_result: registered operands to, and product from, the multiplier
// rsp_valid/rsp_id/rsp_result/rsp_ready: tagged response channel; busy: FSM not IDLE
// FP_MUL_ARB_ZERO_BYPASS_EN: a +/-0 operand returns a signed zero without waiting on the multiplier
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int ID_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  input  logic [FP_W-1:0]         mul_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_result,
  input  logic                    rsp_ready,
  output logic                    busy
);
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ID_W-1:0] ptr_q, rsp_id_q, idx;
  logic [FP_W-1:0] mul_a_q, mul_b_q, rsp_result_q, a_sel, b_sel;
  logic            hs, bypass;
  // Requests are only presented to the arbiter in IDLE, so req_ready is zero elsewhere.
  fp_mul_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i(state_q == IDLE ? req_valid : '0),
    .ptr_i(ptr_q),
    .gnt_o(req_ready),
    .idx_o(idx)
  );
  assign hs    = |req_ready;
  assign a_sel = req_a[FP_W*idx +: FP_W];
  assign b_sel = req_b[FP_W*idx +: FP_W];
`ifdef FP_MUL_ARB_ZERO_BYPASS_EN
  assign bypass = is_zero(a_sel) | is_zero(b_sel);
`else
  assign bypass = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (hs) begin
          mul_a_q  <= a_sel;
          mul_b_q  <= b_sel;
          rsp_id_q <= idx;
          ptr_q    <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
          cnt_q    <= CNT_W'(MUL_LATENCY - 1);
          state_q  <= bypass ? RESP : WAIT;
          if (bypass) rsp_result_q <= {a_sel[FP_W-1] ^ b_sel[FP_W-1], {(FP_W-1){1'b0}}};
        end
        WAIT: if (cnt_q == '0) begin
          rsp_result_q <= mul_result;
          state_q      <= RESP;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_valid  = state_q == RESP;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed and random checks of fp_mul_arbiter against a transaction-level model
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int L = 3;
`ifdef FP_MUL_ARB_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, rsp_valid, rsp_ready, busy;
  logic [N-1:0] req_valid, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0] mul_a, mul_b, mul_result, rsp_result, prod;
  logic [1:0] rsp_id;
  logic [31:0] pipe [L];
  int n_test = 0, n_fail = 0, cyc = 0, hs_cyc = 0;
  bit m_busy;
  int m_due, m_ptr;
  logic [31:0] m_a, m_b, m_res;
  logic [1:0] m_id;
  logic [31:0] opa [N], opb [N];
  int gnt_q[$], rid_q[$], lat_q[$];
  logic [31:0] res_q[$];
  always #5 clk = ~clk;
  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ready(rsp_ready), .busy(busy)
  );
  function automatic bit fz(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction
  function automatic real s2r(input logic [31:0] x);
    return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (fz(a) || fz(b)) return {a[31] ^ b[31], 31'd0};
    return r2s(s2r(a) * s2r(b));
  endfunction
  function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
    return (ZB && (fz(a) || fz(b))) ? 1 : L + 1;
  endfunction
  function automatic logic [31:0] rnd_fp();
    if ($urandom_range(0, 9) == 0) return {1'($urandom), 31'd0};
    return {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
  endfunction
  // Multiplier stand-in: combinational product behind L-1 register stages.
  always_comb prod = fmul(mul_a, mul_b);
  always_ff @(posedge clk) begin
    pipe[0] <= prod;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign mul_result = pipe[L-2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input logic [N-1:0] v, input logic rr, input logic rs, output int og);
    int g;
    logic [N-1:0] er;
    bit ev;
    @(negedge clk);
    rst = rs;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = opa[i];
      req_b[32*i +: 32] = opb[i];
    end
    #1;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (g < 0 && v[p]) g = p;
      end
    er = (g >= 0) ? N'(1) << g : '0;
    ev = m_busy && cyc >= m_due;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("mul_a", mul_a, m_a);
    chk("mul_b", mul_b, m_b);
    if (ev) chk("rsp_result", rsp_result, m_res);
    og = -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) og = i;
    if (og >= 0) begin
      gnt_q.push_back(og);
      hs_cyc = cyc;
    end
    if (rsp_valid && rsp_ready) begin
      rid_q.push_back(int'(rsp_id));
      res_q.push_back(rsp_result);
      lat_q.push_back(cyc - hs_cyc);
    end
    if (rs) begin
      m_busy = 0; m_ptr = 0; m_a = '0; m_b = '0; m_id = '0;
    end else if (g >= 0) begin
      m_busy = 1;
      m_due = cyc + lat_of(opa[g], opb[g]);
      m_ptr = (g + 1) % N;
      m_a = opa[g];
      m_b = opb[g];
      m_id = 2'(g);
      m_res = fmul(opa[g], opb[g]);
    end else if (ev && rr) begin
      m_busy = 0;
    end
    cyc++;
  endtask
  task automatic drain(input int lim);
    int og, n;
    n = 0;
    while (m_busy && n < lim) begin
      step('0, 1'b1, 1'b0, og);
      n++;
    end
    chk("drain_timeout", 32'(m_busy), 32'd0);
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({p, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({p, "_rsp_result"}, rsp_result, 32'd0);
    chk({p, "_mul_a"}, mul_a, 32'd0);
    chk({p, "_mul_b"}, mul_b, 32'd0);
    chk({p, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask
  task automatic clear_q();
    gnt_q.delete(); rid_q.delete(); res_q.delete(); lat_q.delete();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int og, n;
    logic [N-1:0] pend;
    bit p3;
    logic [31:0] ea [N], eb [N], er [N];
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    m_busy = 0; m_ptr = 0; m_a = '0; m_b = '0; m_id = '0; m_res = '0; m_due = 0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    step('0, 1'b1, 1'b1, og);
    // 1: single op on port 0
    clear_q();
    opa[0] = 32'h3FC00000; opb[0] = 32'h40200000;
    step(4'b0001, 1'b1, 1'b0, og);
    drain(30);
    chk("t1_count", 32'(rid_q.size()), 32'd1);
    chk("t1_id", 32'(rid_q[0]), 32'd0);
    chk("t1_result", res_q[0], 32'h40700000);
    chk("t1_latency", 32'(lat_q[0]), 32'(L + 1));
    // 2: all four ports at once from rr_ptr=0
    step('0, 1'b1, 1'b1, og);
    clear_q();
    ea = '{32'hBFA00000, 32'h3F400000, 32'hC0400000, 32'h3FC00000};
    eb = '{32'h40800000, 32'h3F000000, 32'hC0000000, 32'h40200000};
    er = '{32'hC0A00000, 32'h3EC00000, 32'h40C00000, 32'h40700000};
    for (int i = 0; i < N; i++) begin opa[i] = ea[i]; opb[i] = eb[i]; end
    pend = '1; n = 0;
    while ((pend != '0 || m_busy) && n < 200) begin
      step(pend, 1'b1, 1'b0, og);
      if (og >= 0) pend = pend & ~(N'(1) << og);
      n++;
    end
    chk("t2_pending", 32'(pend), 32'd0);
    drain(30);
    chk("t2_count", 32'(rid_q.size()), 32'd4);
    for (int i = 0; i < N; i++) begin
      chk("t2_id", 32'(rid_q[i]), 32'(i));
      chk("t2_result", res_q[i], er[i]);
    end
    // 3: backpressure in RESP
    clear_q();
    step(4'b0100, 1'b0, 1'b0, og);
    chk("t3_grant", 32'(og), 32'd2);
    repeat (L) step(4'b1011, 1'b0, 1'b0, og);
    repeat (5) begin
      step(4'b1011, 1'b0, 1'b0, og);
      chk("t3_valid", 32'(rsp_valid), 32'd1);
      chk("t3_id", 32'(rsp_id), 32'd2);
      chk("t3_result", rsp_result, 32'h40C00000);
      chk("t3_req_ready", 32'(req_ready), 32'd0);
    end
    step('0, 1'b1, 1'b0, og);
    step('0, 1'b1, 1'b0, og);
    chk("t3_idle", 32'(busy), 32'd0);
    // 4: fairness between a persistent port 1 and port 3
    step('0, 1'b1, 1'b1, og);
    step(4'b0010, 1'b1, 1'b0, og);
    drain(30);
    clear_q();
    p3 = 1; n = 0;
    while (gnt_q.size() < 2 && n < 100) begin
      step(4'b0010 | (p3 ? 4'b1000 : 4'b0000), 1'b1, 1'b0, og);
      if (og == 3) p3 = 0;
      n++;
    end
    drain(30);
    chk("t4_grants", 32'(gnt_q.size()), 32'd2);
    chk("t4_first", 32'(gnt_q[0]), 32'd3);
    chk("t4_second", 32'(gnt_q[1]), 32'd1);
    // 5: reset while in WAIT drops the operation
    step(4'b0001, 1'b1, 1'b0, og);
    step('0, 1'b1, 1'b0, og);
    clear_q();
    step('0, 1'b1, 1'b1, og);
    step('0, 1'b1, 1'b0, og);
    chk_reset("t5");
    repeat (6) step('0, 1'b1, 1'b0, og);
    chk("t5_no_rsp", 32'(rid_q.size()), 32'd0);
    // 6: zero operand
    clear_q();
    opa[0] = 32'h00000000; opb[0] = 32'hC0400000;
    step(4'b0001, 1'b1, 1'b0, og);
    drain(30);
    chk("t6_count", 32'(rid_q.size()), 32'd1);
    chk("t6_result", res_q[0], 32'h80000000);
    chk("t6_latency", 32'(lat_q[0]), ZB ? 32'd1 : 32'(L + 1));
    // random traffic with random backpressure
    clear_q();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin opa[i] = rnd_fp(); opb[i] = rnd_fp(); end
      step(N'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'b0, og);
    end
    drain(50);
    chk("rand_rsp_count", 32'(rid_q.size()), 32'(gnt_q.size()));
    for (int i = 0; i < rid_q.size() && i < gnt_q.size(); i++)
      chk("rand_rsp_id", 32'(rid_q[i]), 32'(gnt_q[i]));
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
